// File: rtl/pc_target_unit.sv
// Fetch-stage program counter with a run-time writable branch-target table.
// Taken branches jump to an entry (absolute) or add it as a signed offset (relative).
module pc_target_unit #(
  parameter int             D        = 12,
  parameter int             A        = 3,
  parameter logic [D-1:0]   START_PC = '0
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         stall,
  input  logic         branch,
  input  logic         abs_mode,
  input  logic [A-1:0] how_high,
  input  logic         wr_en,
  input  logic [A-1:0] wr_addr,
  input  logic [D-1:0] wr_data,
  output logic [D-1:0] prog_ctr,
  output logic [D-1:0] target,
  output logic         wrap
);

  localparam int DEPTH = 2 ** A;

  logic [D-1:0] tbl_q [DEPTH];
  logic [D-1:0] pc_q;
  logic [D-1:0] pc_d;
  logic         wrap_q;
  logic         wrap_d;
  logic [D-1:0] target_s;
  logic [D:0]   sum_s;

  // Table read; a same-cycle write to the selected entry is forwarded.
  always_comb begin
    target_s = tbl_q[how_high];
    if (wr_en && (wr_addr == how_high)) begin
      target_s = wr_data;
    end else begin
      target_s = tbl_q[how_high];
    end
  end

  // Next PC selection; sum_s carries one extra bit whose value is the wrap flag.
  always_comb begin
    pc_d   = pc_q;
    wrap_d = 1'b0;
    sum_s  = '0;
    if (stall) begin
      pc_d   = pc_q;
      wrap_d = 1'b0;
    end else if (branch && abs_mode) begin
      pc_d   = target_s;
      wrap_d = 1'b0;
    end else if (branch) begin
      sum_s  = {1'b0, pc_q} + {target_s[D-1], target_s};
      pc_d   = sum_s[D-1:0];
      wrap_d = sum_s[D];
    end else begin
      sum_s  = {1'b0, pc_q} + {{D{1'b0}}, 1'b1};
      pc_d   = sum_s[D-1:0];
      wrap_d = sum_s[D];
    end
  end

  // PC and wrap-pulse registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pc_q   <= START_PC;
      wrap_q <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      wrap_q <= wrap_d;
    end
  end

  // Target table storage; writes proceed regardless of stall or branch.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        tbl_q[i] <= '0;
      end
    end else if (wr_en) begin
      tbl_q[wr_addr] <= wr_data;
    end else begin
      tbl_q[wr_addr] <= tbl_q[wr_addr];
    end
  end

  assign prog_ctr = pc_q;
  assign wrap     = wrap_q;
  assign target   = target_s;

endmodule

// File: tb/tb_pc_target_unit.sv
// Directed bench for pc_target_unit: an integer-arithmetic model is checked every
// negative clock edge, plus literal expectations taken from the test plan.
module tb_pc_target_unit;

  localparam int D = 12;
  localparam int A = 3;
  localparam int MOD = 4096;

  logic         Clk = 1'b0;
  logic         Reset = 1'b0;
  logic         stall = 1'b0;
  logic         branch = 1'b0;
  logic         abs_mode = 1'b0;
  logic [A-1:0] how_high = '0;
  logic         wr_en = 1'b0;
  logic [A-1:0] wr_addr = '0;
  logic [D-1:0] wr_data = '0;
  logic [D-1:0] prog_ctr;
  logic [D-1:0] target;
  logic         wrap;

  int compared = 0;
  int mismatched = 0;
  bit chk_en = 1'b0;

  int m_pc;
  int m_wrap;
  int m_tbl [8];

  pc_target_unit #(.D(D), .A(A), .START_PC(12'd0)) dut (
    .Clk(Clk), .Reset(Reset), .stall(stall), .branch(branch), .abs_mode(abs_mode),
    .how_high(how_high), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .prog_ctr(prog_ctr), .target(target), .wrap(wrap)
  );

  always #20 Clk = ~Clk;

  function automatic int m_target();
    if (wr_en && wr_addr == how_high) return int'(wr_data);
    return m_tbl[how_high];
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_pc = 0;
    m_wrap = 0;
    for (int i = 0; i < 8; i++) m_tbl[i] = 0;
  endtask

  // One clock: model computes the next state from the stable inputs, then the edge.
  task automatic cyc();
    int t, off, n, npc, nwrap;
    t = m_target();
    npc = m_pc;
    nwrap = 0;
    if (stall) begin
      npc = m_pc;
    end else if (branch && abs_mode) begin
      npc = t;
    end else begin
      off = branch ? ((t >= MOD / 2) ? t - MOD : t) : 1;
      n = m_pc + off;
      nwrap = (n < 0 || n >= MOD) ? 1 : 0;
      npc = (n < 0) ? n + MOD : ((n >= MOD) ? n - MOD : n);
    end
    @(posedge Clk);
    if (Reset) begin
      m_reset();
    end else begin
      if (wr_en) m_tbl[wr_addr] = int'(wr_data);
      m_pc = npc;
      m_wrap = nwrap;
    end
    #2;
  endtask

  task automatic wr(input int idx, input int val);
    wr_en = 1'b1; wr_addr = idx[A-1:0]; wr_data = val[D-1:0];
    cyc();
    wr_en = 1'b0;
  endtask

  task automatic jump_abs(input int idx);
    branch = 1'b1; abs_mode = 1'b1; how_high = idx[A-1:0];
    cyc();
    branch = 1'b0; abs_mode = 1'b0;
  endtask

  task automatic all_targets_zero(input string name);
    for (int i = 0; i < 8; i++) begin
      how_high = i[A-1:0];
      #1;
      chk(name, int'(target), 0);
    end
    how_high = '0;
  endtask

  // Model comparison on every falling edge.
  always @(negedge Clk) begin
    if (chk_en) begin
      chk("model_pc", int'(prog_ctr), m_pc);
      chk("model_wrap", int'(wrap), m_wrap);
      chk("model_target", int'(target), m_target());
    end
  end

  initial begin
    #1 Reset = 1'b1;
    #4 m_reset();
    chk_en = 1'b1;
    @(negedge Clk);
    #3 Reset = 1'b0;

    // 1. Reset state and idle counting
    chk("reset_pc", int'(prog_ctr), 0);
    chk("reset_wrap", int'(wrap), 0);
    all_targets_zero("reset_target");
    for (int i = 1; i <= 4; i++) begin
      cyc();
      chk("idle_pc", int'(prog_ctr), i);
      chk("idle_wrap", int'(wrap), 0);
    end

    // 2. Negative relative offset from PC=30
    wr(1, 12'hFED);
    repeat (25) cyc();
    chk("reach_30", int'(prog_ctr), 30);
    branch = 1'b1; abs_mode = 1'b0; how_high = 3'd1;
    cyc();
    branch = 1'b0;
    chk("rel_neg_pc", int'(prog_ctr), 11);
    chk("rel_neg_wrap", int'(wrap), 0);
    cyc();
    chk("rel_neg_next", int'(prog_ctr), 12);

    // 3. Absolute and relative use of the same entry from PC=7
    wr(4, 130);
    wr(7, 7);
    jump_abs(7);
    chk("reach_7a", int'(prog_ctr), 7);
    jump_abs(4);
    chk("abs_pc", int'(prog_ctr), 130);
    jump_abs(7);
    chk("reach_7b", int'(prog_ctr), 7);
    branch = 1'b1; abs_mode = 1'b0; how_high = 3'd4;
    cyc();
    branch = 1'b0;
    chk("rel_pos_pc", int'(prog_ctr), 137);

    // 4. Wrap below zero, then wrap past the top
    wr(5, 12'hF7C);
    wr(6, 5);
    jump_abs(6);
    chk("reach_5", int'(prog_ctr), 5);
    branch = 1'b1; abs_mode = 1'b0; how_high = 3'd5;
    cyc();
    branch = 1'b0;
    chk("wrap_neg_pc", int'(prog_ctr), 3969);
    chk("wrap_neg_flag", int'(wrap), 1);
    cyc();
    chk("wrap_pulse_end", int'(wrap), 0);
    wr(6, 12'hFFF);
    jump_abs(6);
    chk("abs_top_pc", int'(prog_ctr), 4095);
    chk("abs_top_wrap", int'(wrap), 0);
    cyc();
    chk("wrap_top_pc", int'(prog_ctr), 0);
    chk("wrap_top_flag", int'(wrap), 1);
    cyc();
    chk("wrap_top_after", int'(wrap), 0);

    // 5. Write bypass into a branch, then stall with a concurrent write
    wr(7, 10);
    jump_abs(7);
    chk("reach_10", int'(prog_ctr), 10);
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 12'd22;
    branch = 1'b1; abs_mode = 1'b0; how_high = 3'd2;
    #1 chk("bypass_target", int'(target), 22);
    cyc();
    chk("bypass_pc", int'(prog_ctr), 32);
    stall = 1'b1; wr_addr = 3'd3; wr_data = 12'hFE6;
    cyc();
    stall = 1'b0; branch = 1'b0; wr_en = 1'b0; how_high = 3'd3;
    chk("stall_pc", int'(prog_ctr), 32);
    chk("stall_wrap", int'(wrap), 0);
    #1 chk("stall_write", int'(target), 12'hFE6);

    // 6. Asynchronous reset between edges
    jump_abs(4);
    chk("reach_130", int'(prog_ctr), 130);
    #3 Reset = 1'b1;
    #1 m_reset();
    chk("midrst_pc", int'(prog_ctr), 0);
    chk("midrst_wrap", int'(wrap), 0);
    all_targets_zero("midrst_target");
    Reset = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      cyc();
      chk("resume_pc", int'(prog_ctr), i);
    end

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
